// File: rtl/nn_pkg.sv
// Shared constants, map sizing and FSM state for the NN MAC engine.
package nn_pkg;

  localparam int N_IN_D  = 6;
  localparam int N_HID_D = 7;
  localparam int N_OUT_D = 3;
  localparam int W_ACT_D = 12;
  localparam int W_WGT_D = 12;
  localparam int W_ACC_D = 26;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HID,
    S_OUT,
    S_DONE
  } state_t;

  function automatic int map_size(input int ni, input int nh, input int no);
    return nh * (ni + 1) + no * (nh + 1);
  endfunction

  function automatic int wa_w(input int ni, input int nh, input int no);
    return $clog2(map_size(ni, nh, no));
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/nn_mac_sat.sv
// Signed multiply-accumulate with clear and saturation at W_ACC limits.
module nn_mac_sat import nn_pkg::*; #(
  parameter int W_A   = 12,
  parameter int W_B   = 13,
  parameter int W_ACC = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [W_A-1:0]   a,
  input  logic signed [W_B-1:0]   b,
  output logic signed [W_ACC-1:0] acc_nxt
);

  localparam int W_P = W_A + W_B;
  localparam int W_S = ((W_P > W_ACC) ? W_P : W_ACC) + 1;
  localparam logic signed [W_S-1:0] SMAX = W_S'(sat_max(W_ACC));
  localparam logic signed [W_S-1:0] SMIN = W_S'(sat_min(W_ACC));

  logic signed [W_ACC-1:0] acc;
  logic signed [W_P-1:0]   prod;
  logic signed [W_S-1:0]   base;
  logic signed [W_S-1:0]   sum;

  // clr starts a new node: the first term replaces the old sum
  always_comb begin
    prod = a * b;
    base = clr ? '0 : W_S'(acc);
    sum  = W_S'(prod) + base;
    if (sum > SMAX) begin
      acc_nxt = W_ACC'(SMAX);
    end else if (sum < SMIN) begin
      acc_nxt = W_ACC'(SMIN);
    end else begin
      acc_nxt = W_ACC'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/nn_mac_engine.sv
// Two-layer binary-input NN inference on one shared saturating MAC.
// Optional NN_HID_OBS_EN adds the hid_lvl activation level outputs.
module nn_mac_engine import nn_pkg::*; #(
  parameter int N_IN  = N_IN_D,
  parameter int N_HID = N_HID_D,
  parameter int N_OUT = N_OUT_D,
  parameter int W_ACT = W_ACT_D,
  parameter int W_WGT = W_WGT_D,
  parameter int W_ACC = W_ACC_D
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [N_IN-1:0]                in_vec,
  input  logic                           wr_en,
  input  logic [wa_w(N_IN,N_HID,N_OUT)-1:0] wr_addr,
  input  logic signed [W_WGT-1:0]        wr_data,
  output logic                           busy,
  output logic                           valid,
  output logic [$clog2(N_OUT)-1:0]       move,
  output logic [W_ACC-1:0]               score
`ifdef NN_HID_OBS_EN
  ,
  output logic [N_HID*4-1:0]             hid_lvl
`endif
);

  localparam int MS   = map_size(N_IN, N_HID, N_OUT);
  localparam int WA_W = wa_w(N_IN, N_HID, N_OUT);
  localparam int KMAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int NMAX = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int NW   = $clog2(NMAX);
  localparam int MW   = $clog2(N_OUT);
  localparam logic [W_ACC-1:0] ACT_MAX =
    W_ACC'((longint'(1) << W_ACT) - 1);

  logic signed [W_WGT-1:0] wmem [MS];

  state_t                  state;
  logic [WA_W-1:0]         addr;
  logic [KW-1:0]           k;
  logic [KW-1:0]           km1;
  logic [NW-1:0]           nd;
  logic [N_IN-1:0]         in_lat;
  logic [W_ACT-1:0]        act [N_HID];
  logic [W_ACC-1:0]        best_val;
  logic [MW-1:0]           best_idx;

  logic                    xin;
  logic [W_ACT-1:0]        asel;
  logic signed [W_WGT-1:0] wgt;
  logic signed [W_ACT:0]   opb;
  logic signed [W_ACC-1:0] acc_nxt;
  logic [W_ACC-1:0]        relu;
  logic [W_ACT-1:0]        act_v;
  logic                    mac_en;
  logic                    k_last;
  logic                    nd_last;
  logic                    gt;

`ifdef NN_HID_OBS_EN
  function automatic logic [3:0] lvl(input logic [W_ACT-1:0] a);
    logic [W_ACT-1:0] q;
    q = a / W_ACT'(60);
    return (q > W_ACT'(12)) ? 4'd12 : q[3:0];
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst && wr_en && !busy &&
        ((WA_W+1)'(wr_addr) < (WA_W+1)'(MS))) begin
      wmem[wr_addr] <= wr_data;
    end
  end

  // the map is laid out in term order, so one counter walks it
  always_comb begin
    wgt  = wmem[addr];
    km1  = k - KW'(1);
    xin  = 1'b0;
    asel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (km1 == KW'(i)) xin = in_lat[i];
    end
    for (int i = 0; i < N_HID; i++) begin
      if (km1 == KW'(i)) asel = act[i];
    end
    if (k == '0) begin
      opb = (W_ACT+1)'(1);
    end else if (state == S_HID) begin
      opb = {{W_ACT{1'b0}}, xin};
    end else begin
      opb = {1'b0, asel};
    end
  end

  always_comb begin
    mac_en  = (state == S_HID) || (state == S_OUT);
    k_last  = (state == S_HID) ? (k == KW'(N_IN)) : (k == KW'(N_HID));
    nd_last = (state == S_HID) ? (nd == NW'(N_HID - 1))
                               : (nd == NW'(N_OUT - 1));
    relu    = acc_nxt[W_ACC-1] ? '0 : acc_nxt;
    act_v   = (relu > ACT_MAX) ? '1 : relu[W_ACT-1:0];
    gt      = relu > best_val;
  end

  nn_mac_sat #(
    .W_A   (W_WGT),
    .W_B   (W_ACT + 1),
    .W_ACC (W_ACC)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en      (mac_en),
    .clr     (k == '0),
    .a       (wgt),
    .b       (opb),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      move     <= '0;
      score    <= '0;
      addr     <= '0;
      k        <= '0;
      nd       <= '0;
      in_lat   <= '0;
      best_val <= '0;
      best_idx <= '0;
      for (int i = 0; i < N_HID; i++) act[i] <= '0;
`ifdef NN_HID_OBS_EN
      hid_lvl  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HID;
            busy     <= 1'b1;
            addr     <= '0;
            k        <= '0;
            nd       <= '0;
            in_lat   <= in_vec;
            best_val <= '0;
            best_idx <= '0;
          end
        end
        S_HID: begin
          addr <= addr + WA_W'(1);
          if (k_last) begin
            k <= '0;
            for (int i = 0; i < N_HID; i++) begin
              if (nd == NW'(i)) begin
                act[i] <= act_v;
`ifdef NN_HID_OBS_EN
                hid_lvl[i*4 +: 4] <= lvl(act_v);
`endif
              end
            end
            if (nd_last) begin
              nd    <= '0;
              state <= S_OUT;
            end else begin
              nd <= nd + NW'(1);
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        S_OUT: begin
          addr <= addr + WA_W'(1);
          if (k_last) begin
            k <= '0;
            if (gt) begin
              best_val <= relu;
              best_idx <= MW'(nd);
            end
            if (nd_last) begin
              nd    <= '0;
              state <= S_DONE;
              valid <= 1'b1;
              move  <= gt ? MW'(nd) : best_idx;
              score <= gt ? relu : best_val;
            end else begin
              nd <= nd + NW'(1);
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mac_engine.sv
// Directed bench for nn_mac_engine at default parameters.
module tb_nn_mac_engine;
  import nn_pkg::*;

  localparam int WA = wa_w(N_IN_D, N_HID_D, N_OUT_D);
  localparam int MS = map_size(N_IN_D, N_HID_D, N_OUT_D);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [5:0]        in_vec;
  logic              wr_en;
  logic [WA-1:0]     wr_addr;
  logic signed [11:0] wr_data;
  logic              busy;
  logic              valid;
  logic [1:0]        move;
  logic [25:0]       score;

  int checks = 0;
  int errors = 0;
  int vcyc;
  int nv;
  logic        busy_log  [0:101];
  logic [25:0] score_log [0:101];

  always #5 clk = ~clk;

  nn_mac_engine dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_vec  (in_vec),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .valid   (valid),
    .move    (move),
    .score   (score)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = WA'(a);
    wr_data = 12'(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic clr_all();
    for (int a = 0; a < MS; a++) wr(a, 0);
  endtask

  // cs/cw/cr: cycle to inject a start, a write or a reset (-1 = none)
  task automatic run(input logic [5:0] iv, input int cs,
                     input int cw, input int cr);
    vcyc   = -1;
    nv     = 0;
    in_vec = iv;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    in_vec = ~iv;
    for (int c = 1; c <= 101; c++) begin
      start   = (c == cs);
      rst     = (c == cr);
      wr_en   = (c == cw);
      wr_addr = WA'(65);
      wr_data = 12'sd999;
      @(negedge clk);
      busy_log[c]  = busy;
      score_log[c] = score;
      if (valid) begin
        nv++;
        if (vcyc < 0) vcyc = c;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  task automatic res(input string tag, input int mv, input int sc);
    chk({tag, "_vcyc"}, vcyc, 74);
    chk({tag, "_nvalid"}, nv, 1);
    chk({tag, "_move"}, move, mv);
    chk({tag, "_score"}, score, sc);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    wr_en   = 1'b0;
    in_vec  = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_move", move, 0);
    chk("rst_score", score, 0);
    @(posedge clk);
    #1;

    clr_all();
    run(6'h15, -1, -1, -1);
    res("zero", 0, 0);
    chk("busy_c1", busy_log[1], 1);
    chk("busy_c74", busy_log[74], 1);
    chk("busy_c75", busy_log[75], 0);

    wr(65, 5);
    run(6'h00, -1, -1, -1);
    res("o2bias", 2, 5);
    chk("hold_score", score_log[101], 5);

    run(6'h2a, 10, 20, -1);
    res("ignore", 2, 5);
    run(6'h00, -1, -1, -1);
    res("wkeep", 2, 5);

    run(6'h00, -1, -1, 30);
    chk("mrst_nvalid", nv, 0);
    chk("mrst_busy", busy_log[31], 0);
    chk("mrst_score", score_log[31], 0);
    run(6'h00, -1, -1, -1);
    res("rerun", 2, 5);

    wr(65, 0);
    wr(0, 100);
    wr(58, 3);
    run(6'h3f, -1, -1, -1);
    res("h0o1", 1, 300);

    wr(0, 0);
    wr(58, 0);
    wr(49, 7);
    wr(57, 7);
    run(6'h3f, -1, -1, -1);
    res("tie", 0, 7);
    wr(49, 0);
    wr(57, 0);

    for (int a = 0; a <= 6; a++) wr(a, 2047);
    wr(50, 1);
    run(6'h3f, -1, -1, -1);
    res("actclamp", 0, 4095);

    for (int a = 0; a <= 6; a++) wr(a, 0);
    wr(50, 0);
    wr(3, 50);
    wr(58, 2);
    wr(65, 60);
    run(6'b000100, -1, -1, -1);
    res("inbit2", 1, 100);
    run(6'b111011, -1, -1, -1);
    res("inoff", 2, 60);

    clr_all();
    for (int h = 0; h < 7; h++) begin
      wr(h * 7, 2047);
      wr(h * 7 + 1, 2047);
      wr(h * 7 + 2, 2047);
    end
    for (int a = 49; a <= 56; a++) wr(a, 2047);
    run(6'b000011, -1, -1, -1);
    res("satpos", 0, 33554431);

    for (int a = 49; a <= 56; a++) wr(a, 0);
    for (int a = 57; a <= 64; a++) wr(a, -2048);
    wr(65, 10);
    run(6'b000011, -1, -1, -1);
    res("satneg", 2, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_mac_engine.md
NN_MAC_ENGINE -- requirements
Module: nn_mac_engine

Interface
REQ-001 The block SHALL have parameter N_IN, default 6, meaning number of binary inputs.
REQ-002 The block SHALL have parameter N_HID, default 7, meaning number of hidden nodes.
REQ-003 The block SHALL have parameter N_OUT, default 3, meaning number of output nodes (2..16).
REQ-004 The block SHALL have parameter W_ACT, default 12, meaning unsigned hidden activation width.
REQ-005 The block SHALL have parameter W_WGT, default 12, meaning signed two's-complement weight/bias width.
REQ-006 The block SHALL have parameter W_ACC, default 26, meaning signed accumulator width.
REQ-007 The block SHALL have one clock and synchronous, active-high reset, with ports as follows: clk  in  1  clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start  in  1  one-cycle request; accepted only when busy=0.
REQ-010 in_vec  in  N_IN  binary input vector, latched on accepted start.
REQ-011 wr_en  in  1  weight write strobe.
REQ-012 wr_addr  in  WA_W  weight address (WA_W from package function).
REQ-013 wr_data  in  W_WGT  signed weight value.
REQ-014 busy  out  1  inference in progress.
REQ-015 valid  out  1  one-cycle pulse, result ready.
REQ-016 move  out  clog2(N_OUT)  argmax output index.
REQ-017 score  out  W_ACC  winning output's post-ReLU value.

Function
REQ-018 The weight map SHALL be: hidden node h at h*(N_IN+1)+k, then output node o at N_HID*(N_IN+1)+o*(N_HID+1)+k; k=0 bias, k>=1 input/hidden k-1.
REQ-019 wr_en while busy=1 or with wr_addr beyond the map SHALL be ignored; otherwise the write takes effect next cycle.
REQ-020 The FSM SHALL have states IDLE, HID, OUT, DONE; IDLE->HID on start, HID->OUT after the last hidden term, OUT->DONE after the last output term, DONE->IDLE unconditionally.
REQ-021 The engine SHALL use one shared MAC, one term per cycle: bias, then each fan-in term (weight*input for hidden, weight*activation for output).
REQ-022 Hidden activation SHALL be ReLU of the accumulator, saturated to 2^W_ACT-1; output value SHALL be ReLU of the accumulator.
REQ-023 The accumulator SHALL saturate at signed W_ACC limits, with no wrap-around.
REQ-024 Argmax SHALL update incrementally as each output completes, using strict greater-than; ties and all-zero results select the lowest index.
REQ-025 With start accepted at cycle 0, valid SHALL pulse at cycle N_HID*(N_IN+1)+N_OUT*(N_HID+1)+1 (74 at defaults), with move/score valid from then and held until the next valid.
REQ-026 busy SHALL be 1 from the cycle after accepted start through the valid cycle; start while busy=1 SHALL be ignored.
REQ-027 in_vec changes after acceptance SHALL NOT affect the running inference.

Reset
REQ-028 rst SHALL force FSM=IDLE, busy=0, valid=0, move=0, score=0, and clear accumulators and activations, including mid-inference (result discarded, no valid).
REQ-029 Weight storage SHALL NOT be cleared by rst.
REQ-030 rst SHALL take priority over start and wr_en in the same cycle.

Configuration
REQ-031 The macro NN_HID_OBS_EN SHALL, when defined, add output hid_lvl[N_HID*4], with each nibble set to min(activation/60,12) and updated when that hidden node completes, reset to 0.
REQ-032 Without NN_HID_OBS_EN, the hid_lvl port and its dividers SHALL be absent.

Structure
REQ-033 The shared package nn_pkg SHALL hold default parameter constants, the WA_W/map-size functions, the FSM state typedef and the saturation limits.
REQ-034 The MAC SHALL be one sub-module, nn_mac_sat: a signed multiply-accumulate with saturation and clear.

Verification
REQ-035 All weights 0, output-2 bias=5, start -> valid at cycle 74, move=2, score=5.
REQ-036 Hidden-0 bias=100, output-1 weight for hidden-0=3, all else 0 -> move=1, score=300.
REQ-037 All weights 0 -> move=0, score=0 (tie rule).
REQ-038 Hidden-0 bias and all its input weights=2047, in_vec=6'b111111, output-0 weight for hidden-0=1 -> activation clamped 4095, move=0, score=4095.
REQ-039 start at cycle 10 and wr_en at cycle 20 during a run -> both ignored, single valid at cycle 74 with an unchanged result.
REQ-040 rst at cycle 30 mid-run -> busy=0 and no valid; a rerun yields the correct result with weights retained.
